// File: rtl/gate_tt_sequencer_pkg.sv
// gts_pkg: shared FSM state type and reference truth tables for 2-input gates
package gts_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} gts_state_t;
    localparam logic [3:0] NOR2_TT = 4'b0001;
    localparam logic [3:0] AND2_TT = 4'b1000;
    localparam logic [3:0] OR2_TT  = 4'b1110;
    localparam logic [3:0] XOR2_TT = 4'b0110;
endpackage

// File: rtl/gate_tt_sequencer_settle_timer.sv
// gts_settle_timer: counts settle clocks, expire when count reaches SETTLE_CYCLES-1
module gts_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_expire
);
    localparam int W = $clog2(SETTLE_CYCLES + 1);
    logic [W-1:0] r_cnt;
    assign o_expire = r_cnt == W'(SETTLE_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= i_clear ? '0 : o_expire ? r_cnt : r_cnt + W'(1);
endmodule

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: sweeps all GUT input vectors, captures and checks the truth table.
// Optional sticky failure flag output fail_seen when GTS_STICKY_FAIL_EN is defined.
module gate_tt_sequencer
    import gts_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [2**N_INPUTS-1:0] EXPECTED_TT = 4'b0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_INPUTS-1:0]    gate_in,
    input  logic                   gate_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
`ifdef GTS_STICKY_FAIL_EN
    output logic                   fail_seen,
`endif
    output logic [2**N_INPUTS-1:0] truth_table
);
    localparam int ROWS = 2**N_INPUTS;
    gts_state_t r_state;
    logic [N_INPUTS:0] r_vec;
    logic w_expire;
    logic w_last;
    logic [ROWS-1:0] w_tt_next;
    assign w_last = r_vec == (N_INPUTS+1)'(ROWS - 1);
    assign w_tt_next = (truth_table & ~(ROWS'(1) << r_vec)) | (ROWS'(gate_y) << r_vec);
    gts_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state != SETTLE),
        .o_expire(w_expire)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            gate_in     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            truth_table <= '0;
        end else begin
            case (r_state)
                IDLE, DONE:
                    if (start) begin
                        r_state     <= SETTLE;
                        r_vec       <= '0;
                        gate_in     <= '0;
                        truth_table <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                    end
                SETTLE:
                    if (w_expire) r_state <= SAMPLE;
                SAMPLE: begin
                    truth_table <= w_tt_next;
                    if (w_last) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= w_tt_next == EXPECTED_TT;
                    end else begin
                        r_state <= SETTLE;
                        r_vec   <= r_vec + (N_INPUTS+1)'(1);
                        gate_in <= gate_in + N_INPUTS'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
`ifdef GTS_STICKY_FAIL_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            fail_seen <= 1'b0;
        else if (r_state == SAMPLE && w_last && w_tt_next != EXPECTED_TT)
            fail_seen <= 1'b1;
`endif
endmodule
